zap_cache_ctrl_fsm: RTL and testbench

- Per-side (I or D) cache controller sitting directly upstream of the cache tag/data RAM block.
- Accepts CPU word reads/writes and performs the tag compare on the RAM's registered outputs.
- Serves hits from the line and merges write data into the line. Write policy: write-back, write-allocate.
- On a miss, writes back a dirty victim (4-beat Wishbone burst), then refills the line (4-beat burst) and updates the tag/data RAM.

---
 rtl/zap_cache_ctrl_fsm.sv | 188 ++++++++++++++++++
 tb/tb_zap_cache_ctrl_fsm.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_cache_ctrl_fsm.sv
// zap_cache_ctrl_fsm: write-back, write-allocate cache controller that does the
// tag compare on registered RAM outputs and moves lines over 4-beat Wishbone bursts.
module zap_cache_ctrl_fsm #(
    parameter int CACHE_SIZE = 1024
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_cpu_rd,
    input  logic         i_cpu_wr,
    input  logic [31:0]  i_cpu_addr,
    input  logic [31:0]  i_cpu_addr_nxt,
    input  logic [31:0]  i_cpu_dat,
    input  logic [3:0]   i_cpu_ben,
    output logic [31:0]  o_cpu_dat,
    output logic         o_cpu_ack,
    output logic [31:0]  o_ram_addr_nxt,
    output logic [31:0]  o_ram_addr,
    input  logic [127:0] i_ram_line,
    input  logic [27:0]  i_ram_tag,
    input  logic         i_ram_valid,
    input  logic         i_ram_dirty,
    output logic [127:0] o_ram_line,
    output logic [15:0]  o_ram_line_ben,
    output logic         o_ram_tag_wr_en,
    output logic [27:0]  o_ram_tag,
    output logic         o_ram_tag_dirty,
    output logic         o_wb_cyc,
    output logic         o_wb_stb,
    output logic         o_wb_wen,
    output logic [31:0]  o_wb_adr,
    output logic [31:0]  o_wb_dat,
    output logic [3:0]   o_wb_sel,
    output logic [2:0]   o_wb_cti,
    input  logic         i_wb_ack,
    input  logic [31:0]  i_wb_dat
);

    localparam int LINES = CACHE_SIZE / 16;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_BURST = 3'b010;
    localparam logic [2:0] CTI_EOB = 3'b111;

    if (LINES < 1 || (LINES & (LINES - 1)) != 0) begin : g_bad_size
        $error("CACHE_SIZE must be a power-of-two multiple of 16 bytes");
    end

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL,
        UPDATE,
        CMP_WAIT
    } state_t;

    state_t       state, state_nxt;
    logic [1:0]   beat, beat_nxt;
    logic [127:0] victim_line, victim_line_nxt;
    logic [27:0]  victim_tag, victim_tag_nxt;
    logic [127:0] fill_buf, fill_buf_nxt;
    logic         cyc_nxt, stb_nxt, wen_nxt;
    logic [31:0]  adr_nxt, dat_nxt;
    logic [3:0]   sel_nxt;
    logic [2:0]   cti_nxt;

    logic [1:0]   w;
    logic         hit;
    logic [15:0]  wr_ben;
    logic [127:0] merged;
    logic         beat_done;
    logic [1:0]   k;
    logic         wb_wr;

    assign w         = i_cpu_addr[3:2];
    assign hit       = i_ram_valid && (i_ram_tag == i_cpu_addr[31:4]);
    assign wr_ben    = {12'd0, i_cpu_ben} << {w, 2'b00};
    assign beat_done = o_wb_stb && i_wb_ack;
    // Beat to present next: the current one when a burst is launched, else the following one.
    assign k         = o_wb_cyc ? beat + 2'd1 : beat;
    assign wb_wr     = (state == WRITEBACK);
    assign o_ram_addr = i_cpu_addr;

    for (genvar b = 0; b < 16; b++) begin : g_merge
        assign merged[8*b +: 8] = (i_cpu_wr && wr_ben[b]) ? i_cpu_dat[8*(b%4) +: 8] : fill_buf[8*b +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            beat     <= 2'd0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_adr <= 32'd0;
            o_wb_dat <= 32'd0;
            o_wb_sel <= 4'd0;
            o_wb_cti <= CTI_CLASSIC;
        end else begin
            state    <= state_nxt;
            beat     <= beat_nxt;
            o_wb_cyc <= cyc_nxt;
            o_wb_stb <= stb_nxt;
            o_wb_wen <= wen_nxt;
            o_wb_adr <= adr_nxt;
            o_wb_dat <= dat_nxt;
            o_wb_sel <= sel_nxt;
            o_wb_cti <= cti_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        victim_line <= victim_line_nxt;
        victim_tag  <= victim_tag_nxt;
        fill_buf    <= fill_buf_nxt;
    end

    always_comb begin
        state_nxt       = state;
        beat_nxt        = beat;
        victim_line_nxt = victim_line;
        victim_tag_nxt  = victim_tag;
        fill_buf_nxt    = fill_buf;
        cyc_nxt         = o_wb_cyc;
        stb_nxt         = o_wb_stb;
        wen_nxt         = o_wb_wen;
        adr_nxt         = o_wb_adr;
        dat_nxt         = o_wb_dat;
        sel_nxt         = o_wb_sel;
        cti_nxt         = o_wb_cti;
        o_cpu_ack       = 1'b0;
        o_cpu_dat       = i_ram_line[{w, 5'd0} +: 32];
        o_ram_line      = {4{i_cpu_dat}};
        o_ram_line_ben  = 16'd0;
        o_ram_tag_wr_en = 1'b0;
        o_ram_tag       = i_cpu_addr[31:4];
        o_ram_tag_dirty = 1'b0;
        o_ram_addr_nxt  = (state == IDLE) ? i_cpu_addr_nxt : i_cpu_addr;
        case (state)
            IDLE: state_nxt = (i_cpu_rd || i_cpu_wr) ? COMPARE : IDLE;
            COMPARE: begin
                if (hit) begin
                    o_cpu_ack       = 1'b1;
                    o_ram_line_ben  = i_cpu_wr ? wr_ben : 16'd0;
                    o_ram_tag_wr_en = i_cpu_wr;
                    o_ram_tag_dirty = i_cpu_wr;
                    state_nxt       = IDLE;
                end else if (i_ram_valid && i_ram_dirty) begin
                    victim_line_nxt = i_ram_line;
                    victim_tag_nxt  = i_ram_tag;
                    state_nxt       = WRITEBACK;
                end else begin
                    state_nxt = FILL;
                end
            end
            WRITEBACK, FILL: begin
                if (beat_done && !wb_wr)
                    fill_buf_nxt[{beat, 5'd0} +: 32] = i_wb_dat;
                if (beat_done)
                    beat_nxt = beat + 2'd1;
                if (beat_done && beat == 2'd3) begin
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                    wen_nxt   = 1'b0;
                    cti_nxt   = CTI_CLASSIC;
                    state_nxt = wb_wr ? FILL : UPDATE;
                end else if (!o_wb_cyc || beat_done) begin
                    cyc_nxt = 1'b1;
                    stb_nxt = 1'b1;
                    wen_nxt = wb_wr;
                    adr_nxt = {wb_wr ? victim_tag : i_cpu_addr[31:4], k, 2'b00};
                    dat_nxt = wb_wr ? victim_line[{k, 5'd0} +: 32] : 32'd0;
                    sel_nxt = 4'hF;
                    cti_nxt = (k == 2'd3) ? CTI_EOB : CTI_BURST;
                end
            end
            UPDATE: begin
                o_ram_line      = merged;
                o_ram_line_ben  = 16'hFFFF;
                o_ram_tag_wr_en = 1'b1;
                o_ram_tag_dirty = i_cpu_wr;
                state_nxt       = CMP_WAIT;
            end
            CMP_WAIT: state_nxt = COMPARE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_zap_cache_ctrl_fsm.sv
// tb_zap_cache_ctrl_fsm: directed bench for the cache controller with a behavioural
// tag/data RAM (1-cycle read latency) and a Wishbone slave with an optional stall.
`timescale 1ns/1ps
module tb_zap_cache_ctrl_fsm;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_cpu_rd = 1'b0, i_cpu_wr = 1'b0;
    logic [31:0]  i_cpu_addr = 32'd0, i_cpu_addr_nxt = 32'd0, i_cpu_dat = 32'd0;
    logic [3:0]   i_cpu_ben = 4'd0;
    logic [31:0]  o_cpu_dat;
    logic         o_cpu_ack;
    logic [31:0]  o_ram_addr_nxt, o_ram_addr;
    logic [127:0] i_ram_line;
    logic [27:0]  i_ram_tag;
    logic         i_ram_valid, i_ram_dirty;
    logic [127:0] o_ram_line;
    logic [15:0]  o_ram_line_ben;
    logic         o_ram_tag_wr_en;
    logic [27:0]  o_ram_tag;
    logic         o_ram_tag_dirty;
    logic         o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [31:0]  o_wb_adr, o_wb_dat;
    logic [3:0]   o_wb_sel;
    logic [2:0]   o_wb_cti;
    logic         i_wb_ack;
    logic [31:0]  i_wb_dat;

    int tests = 0;
    int fails = 0;
    logic stall = 1'b0;

    zap_cache_ctrl_fsm #(.CACHE_SIZE(1024)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cpu_rd(i_cpu_rd), .i_cpu_wr(i_cpu_wr), .i_cpu_addr(i_cpu_addr),
        .i_cpu_addr_nxt(i_cpu_addr_nxt), .i_cpu_dat(i_cpu_dat), .i_cpu_ben(i_cpu_ben),
        .o_cpu_dat(o_cpu_dat), .o_cpu_ack(o_cpu_ack),
        .o_ram_addr_nxt(o_ram_addr_nxt), .o_ram_addr(o_ram_addr),
        .i_ram_line(i_ram_line), .i_ram_tag(i_ram_tag), .i_ram_valid(i_ram_valid),
        .i_ram_dirty(i_ram_dirty), .o_ram_line(o_ram_line), .o_ram_line_ben(o_ram_line_ben),
        .o_ram_tag_wr_en(o_ram_tag_wr_en), .o_ram_tag(o_ram_tag), .o_ram_tag_dirty(o_ram_tag_dirty),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen), .o_wb_adr(o_wb_adr),
        .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_cti(o_wb_cti),
        .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat)
    );

    always #5 i_clk = ~i_clk;

    // Wishbone slave: zero-wait unless stalled; read data is a fixed function of the address.
    assign i_wb_ack = o_wb_cyc && o_wb_stb && !stall;
    assign i_wb_dat = {16'hC0DE, o_wb_adr[15:0]};

    // 64-line tag/data RAM, read-first, registered outputs.
    logic [127:0] mem_line [64] = '{default: 128'd0};
    logic [27:0]  mem_tag [64] = '{default: 28'd0};
    logic         mem_valid [64] = '{default: 1'b0};
    logic         mem_dirty [64] = '{default: 1'b0};
    logic [127:0] ram_tmp;

    always @(posedge i_clk) begin
        i_ram_line  <= mem_line[o_ram_addr_nxt[9:4]];
        i_ram_tag   <= mem_tag[o_ram_addr_nxt[9:4]];
        i_ram_valid <= mem_valid[o_ram_addr_nxt[9:4]];
        i_ram_dirty <= mem_dirty[o_ram_addr_nxt[9:4]];
        ram_tmp = mem_line[o_ram_addr[9:4]];
        for (int b = 0; b < 16; b++)
            if (o_ram_line_ben[b]) ram_tmp[8*b +: 8] = o_ram_line[8*b +: 8];
        mem_line[o_ram_addr[9:4]] <= ram_tmp;
        if (o_ram_tag_wr_en) begin
            mem_tag[o_ram_addr[9:4]]   <= o_ram_tag;
            mem_valid[o_ram_addr[9:4]] <= 1'b1;
            mem_dirty[o_ram_addr[9:4]] <= o_ram_tag_dirty;
        end
    end

    // Transaction logs: Wishbone beats, tag writes, CPU acks, cycles with cyc high.
    logic [31:0]  b_adr [64];
    logic [31:0]  b_dat [64];
    logic [2:0]   b_cti [64];
    logic         b_wen [64];
    logic [3:0]   b_sel [64];
    logic [27:0]  t_tag [32];
    logic         t_dirty [32];
    logic [15:0]  t_ben [32];
    logic [127:0] t_line [32];
    int nbeats = 0, ntags = 0, nacks = 0, ncyc = 0;

    always @(posedge i_clk) begin
        if (i_wb_ack) begin
            if (nbeats < 64) begin
                b_adr[nbeats] <= o_wb_adr;
                b_dat[nbeats] <= o_wb_dat;
                b_cti[nbeats] <= o_wb_cti;
                b_wen[nbeats] <= o_wb_wen;
                b_sel[nbeats] <= o_wb_sel;
            end
            nbeats <= nbeats + 1;
        end
        if (o_ram_tag_wr_en) begin
            if (ntags < 32) begin
                t_tag[ntags]   <= o_ram_tag;
                t_dirty[ntags] <= o_ram_tag_dirty;
                t_ben[ntags]   <= o_ram_line_ben;
                t_line[ntags]  <= o_ram_line;
            end
            ntags <= ntags + 1;
        end
        if (o_cpu_ack) nacks <= nacks + 1;
        if (o_wb_cyc) ncyc <= ncyc + 1;
    end

    // Drives a request right after a posedge; returns negedges until ack and the read data.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] dat,
                          input logic [3:0] ben, output int cyc_n, output logic [31:0] rdat);
        i_cpu_addr = addr;
        i_cpu_addr_nxt = addr;
        i_cpu_dat = dat;
        i_cpu_ben = ben;
        i_cpu_rd = !wr;
        i_cpu_wr = wr;
        cyc_n = 0;
        rdat = 'x;
        while (cyc_n < 200) begin
            @(negedge i_clk);
            cyc_n++;
            if (o_cpu_ack) begin
                rdat = o_cpu_dat;
                break;
            end
        end
        if (cyc_n >= 200) $display("FAIL req_timeout addr=%h: no ack within 200 cycles", addr);
        @(posedge i_clk);
        #1;
        i_cpu_rd = 1'b0;
        i_cpu_wr = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_cpu_addr = 32'hDEAD_BEE0;
        i_cpu_addr_nxt = 32'h1234_5670;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        tests++; if ({o_wb_cyc, o_wb_stb, o_wb_wen} !== 3'b000) begin fails++; $display("FAIL reset_wb_ctl: got %b want 000", {o_wb_cyc, o_wb_stb, o_wb_wen}); end
        tests++; if (o_wb_cti !== 3'b000) begin fails++; $display("FAIL reset_cti: got %b want 000", o_wb_cti); end
        tests++; if ({o_wb_adr, o_wb_dat, o_wb_sel} !== 68'd0) begin fails++; $display("FAIL reset_wb_bus: adr=%h dat=%h sel=%h want 0", o_wb_adr, o_wb_dat, o_wb_sel); end
        tests++; if ({o_cpu_ack, o_ram_tag_wr_en, o_ram_line_ben} !== 18'd0) begin fails++; $display("FAIL reset_strobes: ack=%b twe=%b ben=%h want 0", o_cpu_ack, o_ram_tag_wr_en, o_ram_line_ben); end
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        tests++; if (o_ram_addr_nxt !== 32'h1234_5670) begin fails++; $display("FAIL idle_addr_nxt: got %h want 12345670", o_ram_addr_nxt); end
        tests++; if (o_ram_addr !== 32'hDEAD_BEE0) begin fails++; $display("FAIL ram_addr: got %h want deadbee0", o_ram_addr); end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_cold_read();
        int c;
        logic [31:0] d;
        int b0 = nbeats;
        int t0 = ntags;
        do_req(1'b0, 32'h0000_1004, 32'd0, 4'd0, c, d);
        tests++; if (d !== 32'hC0DE_1004) begin fails++; $display("FAIL cold_read_data: got %h want c0de1004", d); end
        tests++; if (nbeats - b0 != 4) begin fails++; $display("FAIL cold_read_beats: got %0d want 4", nbeats - b0); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (b_adr[b0+i] !== 32'h1000 + 32'(4*i) || b_wen[b0+i] !== 1'b0 || b_sel[b0+i] !== 4'hF ||
                b_cti[b0+i] !== (i == 3 ? 3'b111 : 3'b010)) begin
                fails++;
                $display("FAIL cold_fill_beat%0d: adr=%h wen=%b sel=%h cti=%b want adr=%h wen=0 sel=f cti=%b",
                         i, b_adr[b0+i], b_wen[b0+i], b_sel[b0+i], b_cti[b0+i], 32'h1000 + 32'(4*i), (i == 3 ? 3'b111 : 3'b010));
            end
        end
        tests++; if (ntags - t0 != 1 || t_tag[t0] !== 28'h0000100 || t_dirty[t0] !== 1'b0 || t_ben[t0] !== 16'hFFFF) begin fails++; $display("FAIL cold_tag_write: n=%0d tag=%h dirty=%b ben=%h want n=1 tag=0000100 dirty=0 ben=ffff", ntags - t0, t_tag[t0], t_dirty[t0], t_ben[t0]); end
        tests++; if (t_line[t0] !== {32'hC0DE100C, 32'hC0DE1008, 32'hC0DE1004, 32'hC0DE1000}) begin fails++; $display("FAIL cold_line: got %h", t_line[t0]); end
    endtask

    task automatic test_read_hit();
        int c;
        logic [31:0] d;
        int n0 = ncyc;
        do_req(1'b0, 32'h0000_100C, 32'd0, 4'd0, c, d);
        tests++; if (c != 2) begin fails++; $display("FAIL hit_latency: got %0d want 2", c); end
        tests++; if (d !== 32'hC0DE_100C) begin fails++; $display("FAIL hit_data: got %h want c0de100c", d); end
        tests++; if (ncyc != n0) begin fails++; $display("FAIL hit_no_cyc: cyc cycles %0d want 0", ncyc - n0); end
    endtask

    task automatic test_write_hit();
        int c;
        logic [31:0] d;
        int t0 = ntags;
        do_req(1'b1, 32'h0000_1008, 32'hAABB_CCDD, 4'b0011, c, d);
        tests++; if (c != 2) begin fails++; $display("FAIL whit_latency: got %0d want 2", c); end
        tests++; if (ntags - t0 != 1 || t_ben[t0] !== 16'h0300 || t_dirty[t0] !== 1'b1 || t_tag[t0] !== 28'h0000100) begin fails++; $display("FAIL whit_tag_write: n=%0d ben=%h dirty=%b tag=%h want n=1 ben=0300 dirty=1 tag=0000100", ntags - t0, t_ben[t0], t_dirty[t0], t_tag[t0]); end
        tests++; if (t_line[t0][95:64] !== 32'hAABB_CCDD) begin fails++; $display("FAIL whit_line_word: got %h want aabbccdd", t_line[t0][95:64]); end
        do_req(1'b0, 32'h0000_1008, 32'd0, 4'd0, c, d);
        tests++; if (d !== 32'hC0DE_CCDD || c != 2) begin fails++; $display("FAIL whit_readback: data=%h lat=%0d want c0deccdd lat=2", d, c); end
    endtask

    task automatic test_dirty_evict();
        int c;
        logic [31:0] d;
        int b0 = nbeats;
        int t0 = ntags;
        logic [31:0] vic [4] = '{32'hC0DE_1000, 32'hC0DE_1004, 32'hC0DE_CCDD, 32'hC0DE_100C};
        logic [31:0] ea;
        do_req(1'b0, 32'h0000_2008, 32'd0, 4'd0, c, d);
        tests++; if (d !== 32'hC0DE_2008) begin fails++; $display("FAIL evict_data: got %h want c0de2008", d); end
        tests++; if (nbeats - b0 != 8) begin fails++; $display("FAIL evict_beats: got %0d want 8", nbeats - b0); end
        for (int i = 0; i < 8; i++) begin
            ea = (i < 4 ? 32'h1000 : 32'h2000) + 32'(4 * (i % 4));
            tests++;
            if (b_adr[b0+i] !== ea || b_wen[b0+i] !== (i < 4) || b_cti[b0+i] !== (i % 4 == 3 ? 3'b111 : 3'b010) ||
                (i < 4 && b_dat[b0+i] !== vic[i])) begin
                fails++;
                $display("FAIL evict_beat%0d: adr=%h wen=%b cti=%b dat=%h want adr=%h wen=%b", i,
                         b_adr[b0+i], b_wen[b0+i], b_cti[b0+i], b_dat[b0+i], ea, (i < 4));
            end
        end
        tests++; if (ntags - t0 != 1 || t_tag[t0] !== 28'h0000200 || t_dirty[t0] !== 1'b0) begin fails++; $display("FAIL evict_tag_write: n=%0d tag=%h dirty=%b want n=1 tag=0000200 dirty=0", ntags - t0, t_tag[t0], t_dirty[t0]); end
    endtask

    task automatic test_write_miss();
        int c;
        logic [31:0] d;
        int b0 = nbeats;
        int t0 = ntags;
        do_req(1'b1, 32'h0000_400C, 32'h1122_3344, 4'b1100, c, d);
        tests++; if (nbeats - b0 != 4 || b_adr[b0] !== 32'h4000 || b_wen[b0] !== 1'b0) begin fails++; $display("FAIL wmiss_beats: n=%0d adr0=%h wen0=%b want n=4 adr0=4000 wen0=0", nbeats - b0, b_adr[b0], b_wen[b0]); end
        tests++; if (ntags - t0 != 2 || t_tag[t0] !== 28'h0000400 || t_dirty[t0] !== 1'b1 || t_ben[t0] !== 16'hFFFF) begin fails++; $display("FAIL wmiss_update: n=%0d tag=%h dirty=%b ben=%h want n=2 tag=0000400 dirty=1 ben=ffff", ntags - t0, t_tag[t0], t_dirty[t0], t_ben[t0]); end
        tests++; if (t_line[t0] !== {32'h1122_400C, 32'hC0DE_4008, 32'hC0DE_4004, 32'hC0DE_4000}) begin fails++; $display("FAIL wmiss_merge: got %h", t_line[t0]); end
        tests++; if (t_ben[t0+1] !== 16'hC000 || t_dirty[t0+1] !== 1'b1) begin fails++; $display("FAIL wmiss_rehit: ben=%h dirty=%b want c000 1", t_ben[t0+1], t_dirty[t0+1]); end
        do_req(1'b0, 32'h0000_400C, 32'd0, 4'd0, c, d);
        tests++; if (d !== 32'h1122_400C) begin fails++; $display("FAIL wmiss_readback: got %h want 1122400c", d); end
    endtask

    task automatic test_wait_states();
        int c;
        logic [31:0] d;
        int b0 = nbeats;
        fork
            do_req(1'b0, 32'h0000_5054, 32'd0, 4'd0, c, d);
            begin
                int n = 0;
                while (nbeats - b0 < 2 && n < 100) begin
                    @(negedge i_clk);
                    n++;
                end
                tests++; if (n >= 100) begin fails++; $display("FAIL wait_reach_beat2: timeout after %0d cycles", n); end
                stall = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge i_clk);
                    tests++;
                    if (o_wb_adr !== 32'h5058 || o_wb_stb !== 1'b1 || o_wb_cyc !== 1'b1 || o_wb_cti !== 3'b010) begin
                        fails++;
                        $display("FAIL wait_hold%0d: adr=%h stb=%b cyc=%b cti=%b want 5058 1 1 010", i, o_wb_adr, o_wb_stb, o_wb_cyc, o_wb_cti);
                    end
                end
                stall = 1'b0;
            end
        join
        tests++; if (d !== 32'hC0DE_5054) begin fails++; $display("FAIL wait_data: got %h want c0de5054", d); end
        tests++; if (nbeats - b0 != 4 || b_adr[b0+2] !== 32'h5058 || b_adr[b0+3] !== 32'h505C) begin fails++; $display("FAIL wait_beats: n=%0d adr2=%h adr3=%h want 4 5058 505c", nbeats - b0, b_adr[b0+2], b_adr[b0+3]); end
    endtask

    task automatic test_reset_mid_burst();
        int b0 = nbeats;
        int t0 = ntags;
        int a0 = nacks;
        int n = 0;
        i_cpu_addr = 32'h0000_3044;
        i_cpu_addr_nxt = 32'h0000_3044;
        i_cpu_rd = 1'b1;
        while (nbeats - b0 < 2 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        tests++; if (n >= 100 || o_wb_adr !== 32'h3048) begin fails++; $display("FAIL rst_reach_beat2: cycles=%0d adr=%h want adr 3048", n, o_wb_adr); end
        i_cpu_addr_nxt = 32'h0000_0ABC;
        i_reset = 1'b1;
        @(negedge i_clk);
        tests++; if ({o_wb_cyc, o_wb_stb} !== 2'b00 || o_wb_cti !== 3'b000) begin fails++; $display("FAIL rst_drop_cyc: cyc=%b stb=%b cti=%b want 0 0 000", o_wb_cyc, o_wb_stb, o_wb_cti); end
        tests++; if (o_ram_addr_nxt !== 32'h0000_0ABC || o_cpu_ack !== 1'b0) begin fails++; $display("FAIL rst_idle: addr_nxt=%h ack=%b want 00000abc 0", o_ram_addr_nxt, o_cpu_ack); end
        i_reset = 1'b0;
        i_cpu_rd = 1'b0;
        repeat (3) @(negedge i_clk);
        tests++; if (ntags != t0 || nacks != a0) begin fails++; $display("FAIL rst_no_side_effects: tag writes=%0d acks=%0d want 0 0", ntags - t0, nacks - a0); end
        tests++; if (mem_valid[4] !== 1'b0 || o_wb_cyc !== 1'b0) begin fails++; $display("FAIL rst_line_unwritten: valid=%b cyc=%b want 0 0", mem_valid[4], o_wb_cyc); end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_dirty_evict();
        test_write_miss();
        test_wait_states();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
